// File: rtl/ens_vote_pkg.sv
// Shared defaults, width helpers and FSM state type for the ensemble vote/argmax stage.
package ens_vote_pkg;

   localparam int unsigned DEF_NUM_CLASSES = 10;
   localparam int unsigned DEF_ENS_MEMBERS = 4;

   // Width needed to index n items; never narrower than one bit.
   function automatic int unsigned cls_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width needed to hold a count in 0..m.
   function automatic int unsigned cnt_w(input int unsigned m);
      return (m > 0) ? $clog2(m + 1) : 1;
   endfunction

   typedef enum logic [1:0] {
      StAccum = 2'd0,
      StScan  = 2'd1,
      StHold  = 2'd2
   } vote_state_e;

endpackage

// File: rtl/ens_vote_counters.sv
// Per-class vote counter array: accumulates one vote bit per class per enabled beat.
module ens_vote_counters
   import ens_vote_pkg::*;
#(
   parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int unsigned CNT_W       = cnt_w(DEF_ENS_MEMBERS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_acc_en,
   input  logic                         i_clr,
   input  logic [NUM_CLASSES-1:0]       i_votes,
   output logic [NUM_CLASSES*CNT_W-1:0] o_count_flat
);

   logic [CNT_W-1:0] r_cnt [NUM_CLASSES];

   // Counts are bounded by the member count, so plain addition never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(NUM_CLASSES); k++) begin
            r_cnt[k] <= '0;
         end
      end else if (i_clr) begin
         for (int k = 0; k < int'(NUM_CLASSES); k++) begin
            r_cnt[k] <= '0;
         end
      end else if (i_acc_en) begin
         for (int k = 0; k < int'(NUM_CLASSES); k++) begin
            r_cnt[k] <= r_cnt[k] + CNT_W'(i_votes[k]);
         end
      end
   end

   for (genvar g = 0; g < int'(NUM_CLASSES); g++) begin : g_flat
      assign o_count_flat[g*CNT_W +: CNT_W] = r_cnt[g];
   end

endmodule

// File: rtl/ens_vote_argmax.sv
// Ensemble vote accumulator with sequential argmax scan and valid/ready result port.
// Optional ENS_VOTE_STATS_EN exposes the winning count and a tie flag.
module ens_vote_argmax
   import ens_vote_pkg::*;
#(
   parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int unsigned ENS_MEMBERS = DEF_ENS_MEMBERS,
   parameter int unsigned CLS_W       = cls_w(NUM_CLASSES),
   parameter int unsigned CNT_W       = cnt_w(ENS_MEMBERS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NUM_CLASSES-1:0] in_votes,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CLS_W-1:0]       out_class
`ifdef ENS_VOTE_STATS_EN
   ,
   output logic [CNT_W-1:0]       out_count,
   output logic                   out_tie
`endif
);

   localparam int unsigned BEAT_W = cls_w(ENS_MEMBERS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ENS_MEMBERS - 1);
   localparam logic [CLS_W-1:0]  LAST_CLS  = CLS_W'(NUM_CLASSES - 1);

   vote_state_e               r_state;
   logic [BEAT_W-1:0]         r_beat;
   logic [CLS_W-1:0]          r_idx;
   logic [CLS_W-1:0]          r_best_cls;
   logic [CNT_W-1:0]          r_best_cnt;
   logic                      r_in_ready;
   logic                      r_out_valid;
`ifdef ENS_VOTE_STATS_EN
   logic                      r_tie;
`endif

   logic                         w_accept;
   logic                         w_release;
   logic [NUM_CLASSES*CNT_W-1:0] w_count_flat;
   logic [CNT_W-1:0]             w_counts [NUM_CLASSES];
   logic [CNT_W-1:0]             w_cur_cnt;

   assign w_accept  = in_valid && r_in_ready;
   assign w_release = r_out_valid && out_ready;

   ens_vote_counters #(
      .NUM_CLASSES (NUM_CLASSES),
      .CNT_W       (CNT_W)
   ) u_counters (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_acc_en     (w_accept),
      .i_clr        (w_release),
      .i_votes      (in_votes),
      .o_count_flat (w_count_flat)
   );

   for (genvar g = 0; g < int'(NUM_CLASSES); g++) begin : g_unpack
      assign w_counts[g] = w_count_flat[g*CNT_W +: CNT_W];
   end

   assign w_cur_cnt = w_counts[r_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StAccum;
         r_beat      <= '0;
         r_idx       <= '0;
         r_best_cls  <= '0;
         r_best_cnt  <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
`ifdef ENS_VOTE_STATS_EN
         r_tie       <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            StAccum: begin
               if (w_accept) begin
                  if (r_beat == LAST_BEAT) begin
                     r_state    <= StScan;
                     r_in_ready <= 1'b0;
                     r_idx      <= '0;
                     r_best_cls <= '0;
                     r_best_cnt <= '0;
`ifdef ENS_VOTE_STATS_EN
                     r_tie      <= 1'b0;
`endif
                  end else begin
                     r_beat <= r_beat + 1'b1;
                  end
               end
            end
            StScan: begin
               // Strictly-greater keeps the lowest index on equal counts.
               if (w_cur_cnt > r_best_cnt) begin
                  r_best_cls <= r_idx;
                  r_best_cnt <= w_cur_cnt;
`ifdef ENS_VOTE_STATS_EN
                  r_tie      <= 1'b0;
`endif
               end
`ifdef ENS_VOTE_STATS_EN
               else if ((w_cur_cnt == r_best_cnt) && (r_idx != '0)) begin
                  r_tie <= 1'b1;
               end
`endif
               if (r_idx == LAST_CLS) begin
                  r_state     <= StHold;
                  r_out_valid <= 1'b1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            StHold: begin
               if (out_ready) begin
                  r_state     <= StAccum;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_beat      <= '0;
                  r_idx       <= '0;
               end
            end
            default: begin
               r_state     <= StAccum;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_beat      <= '0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_class = r_best_cls;
`ifdef ENS_VOTE_STATS_EN
   assign out_count = r_best_cnt;
   assign out_tie   = r_tie;
`endif

endmodule

// File: tb/tb_ens_vote_argmax.sv
// Self-checking bench for ens_vote_argmax: directed vector table, corner sequences, random model.
module tb_ens_vote_argmax;

   localparam int NC = 10;
   localparam int EM = 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [NC-1:0] in_votes;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    out_class;
`ifdef ENS_VOTE_STATS_EN
   logic [2:0]    out_count;
   logic          out_tie;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   ens_vote_argmax dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_votes  (in_votes),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class)
`ifdef ENS_VOTE_STATS_EN
      ,
      .out_count (out_count),
      .out_tie   (out_tie)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [EM*NC-1:0] votes;
      logic [3:0]       cls;
      logic [2:0]       cnt;
      logic             tie;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one beat and hold it until the block takes it.
   task automatic send_beat(input logic [NC-1:0] v);
      int n;
      in_valid = 1'b1;
      in_votes = v;
      n = 0;
      while (!in_ready && n < 100) begin
         step();
         n++;
      end
      check("accept_timeout", int'(n < 100), 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic send_sample(input logic [EM*NC-1:0] v, input int max_gap, output int lat);
      for (int b = 0; b < EM; b++) begin
         int g;
         g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         for (int i = 0; i < g; i++) step();
         send_beat(v[b*NC +: NC]);
      end
      lat = 0;
      while (!out_valid && lat < 50) begin
         step();
         lat++;
      end
      check("result_timeout", int'(lat < 50), 1);
   endtask

   task automatic check_result(input string tag, input int cls, input int cnt, input int tie);
      check({tag, "_class"}, int'(out_class), cls);
`ifdef ENS_VOTE_STATS_EN
      check({tag, "_count"}, int'(out_count), cnt);
      check({tag, "_tie"}, int'(out_tie), tie);
`else
      if (cnt < 0 || tie < 0) $display("unexpected negative expectation");
`endif
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("post_hs_in_ready", int'(in_ready), 1);
      check("post_hs_out_valid", int'(out_valid), 0);
   endtask

   // Reference: tally votes per class, pick the first maximum, flag any other class at that count.
   task automatic ref_model(input logic [EM*NC-1:0] v, output int cls, output int cnt,
                            output int tie);
      int counts [NC];
      for (int k = 0; k < NC; k++) counts[k] = 0;
      for (int b = 0; b < EM; b++)
         for (int k = 0; k < NC; k++)
            counts[k] += int'(v[b*NC + k]);
      cls = 0;
      cnt = counts[0];
      for (int k = 1; k < NC; k++)
         if (counts[k] > cnt) begin
            cls = k;
            cnt = counts[k];
         end
      tie = 0;
      for (int k = 0; k < NC; k++)
         if (k != cls && counts[k] == cnt) tie = 1;
   endtask

   vec_t tbl [6];

   initial begin
      int lat;
      int e_cls, e_cnt, e_tie;
      logic [NC-1:0] held_cls;

      tbl[0] = '{votes: {10'h008, 10'h008, 10'h008, 10'h008}, cls: 4'd3, cnt: 3'd4, tie: 1'b0};
      tbl[1] = '{votes: {10'h004, 10'h004, 10'h001, 10'h001}, cls: 4'd0, cnt: 3'd2, tie: 1'b1};
      tbl[2] = '{votes: {10'h000, 10'h000, 10'h000, 10'h000}, cls: 4'd0, cnt: 3'd0, tie: 1'b1};
      tbl[3] = '{votes: {10'h200, 10'h200, 10'h200, 10'h200}, cls: 4'd9, cnt: 3'd4, tie: 1'b0};
      tbl[4] = '{votes: {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}, cls: 4'd0, cnt: 3'd4, tie: 1'b1};
      tbl[5] = '{votes: {10'h240, 10'h200, 10'h041, 10'h050}, cls: 4'd6, cnt: 3'd3, tie: 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_votes  = '0;
      out_ready = 1'b0;
      #12;
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_class", int'(out_class), 0);
`ifdef ENS_VOTE_STATS_EN
      check("reset_out_count", int'(out_count), 0);
      check("reset_out_tie", int'(out_tie), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Directed table, no gaps: latency must be exactly NC cycles after the last beat edge.
      for (int i = 0; i < 6; i++) begin
         send_sample(tbl[i].votes, 0, lat);
         check($sformatf("tbl%0d_latency", i), lat, NC);
         check_result($sformatf("tbl%0d", i), int'(tbl[i].cls), int'(tbl[i].cnt),
                      int'(tbl[i].tie));
         check($sformatf("tbl%0d_hold_in_ready", i), int'(in_ready), 0);
         release_result();
      end

      // Backpressure: result holds for 20 cycles, a beat offered meanwhile is ignored.
      send_sample({10'h008, 10'h008, 10'h008, 10'h008}, 0, lat);
      held_cls = NC'(out_class);
      in_valid = 1'b1;
      in_votes = 10'h002;
      for (int i = 0; i < 20; i++) begin
         step();
         check("stall_out_valid", int'(out_valid), 1);
         check("stall_out_class", int'(out_class), int'(held_cls));
         check("stall_in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      check_result("stall", 3, 4, 0);
      release_result();
      // A counted stray beat or uncleared counters would pull the winner away from class 0.
      send_sample({10'h002, 10'h002, 10'h001, 10'h001}, 0, lat);
      check_result("after_stall", 0, 2, 1);
      release_result();

      // Reset in the middle of the scan.
      for (int b = 0; b < EM; b++) send_beat(10'h010);
      for (int i = 0; i < 5; i++) step();
      rst_n = 1'b0;
      #1;
      check("midscan_rst_out_valid", int'(out_valid), 0);
      check("midscan_rst_in_ready", int'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      send_sample({10'h200, 10'h200, 10'h200, 10'h200}, 0, lat);
      check("post_rst_latency", lat, NC);
      check_result("post_rst", 9, 4, 0);
      release_result();

      // Random samples with source gaps, sink always ready.
      out_ready = 1'b1;
      for (int s = 0; s < 100; s++) begin
         logic [EM*NC-1:0] v;
         for (int b = 0; b < EM; b++)
            v[b*NC +: NC] = NC'($urandom_range(0, 1023) & $urandom_range(0, 1023));
         ref_model(v, e_cls, e_cnt, e_tie);
         send_sample(v, 3, lat);
         check_result($sformatf("rand%0d", s), e_cls, e_cnt, e_tie);
         step();
         check("rand_in_ready", int'(in_ready), 1);
      end
      out_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
